// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: req/done handshake, registered one-hot grant, owner data mux.
// Optional per-owner hold limit enabled with `define BUS_ARB_TIMEOUT_EN.
module bus_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 32,
  parameter int MAX_HOLD = 15
) (
  input  logic                     i_SYS_CLOCK,
  input  logic                     i_CLEAR_n,
  input  logic                     i_HALT,
  input  logic [N_REQ-1:0]         i_REQ,
  input  logic [N_REQ-1:0]         i_DONE,
  input  logic [N_REQ*WIDTH-1:0]   i_DATA,
  output logic [N_REQ-1:0]         o_GNT,
  output logic [WIDTH-1:0]         o_BUS,
  output logic                     o_BUS_VALID,
  output logic [$clog2(N_REQ)-1:0] o_OWNER,
  output logic                     o_TIMEOUT
);

  localparam int              PW     = $clog2(N_REQ);
  localparam logic [PW:0]     L_N    = (PW+1)'(N_REQ);
  localparam logic [PW-1:0]   L_LAST = PW'(N_REQ-1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  if (N_REQ < 2 || MAX_HOLD < 1) begin : g_param_check
    $error("bus_arbiter: N_REQ must be >= 2 and MAX_HOLD >= 1");
  end

  // First requester at or after ptr, wrapping modulo N_REQ (safe for non-power-of-two N_REQ).
  function automatic logic [PW-1:0] f_pick(input logic [N_REQ-1:0] req, input logic [PW-1:0] ptr);
    logic [PW:0]   v_idx;
    logic [PW-1:0] v_pick;
    logic          v_found;
    v_pick  = ptr;
    v_found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      v_idx = {1'b0, ptr} + (PW+1)'(i);
      if (v_idx >= L_N) begin
        v_idx = v_idx - L_N;
      end else begin
        v_idx = v_idx;
      end
      if (!v_found && req[v_idx[PW-1:0]]) begin
        v_pick  = v_idx[PW-1:0];
        v_found = 1'b1;
      end else begin
        v_found = v_found;
      end
    end
    return v_pick;
  endfunction

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] owner);
    return (owner == L_LAST) ? {PW{1'b0}} : owner + PW'(1);
  endfunction

  function automatic logic [N_REQ-1:0] f_onehot(input logic [PW-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

  state_t           r_state, w_state_nxt;
  logic [PW-1:0]    r_ptr, w_ptr_nxt;
  logic [PW-1:0]    r_owner, w_owner_nxt;
  logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [PW-1:0]    w_pick;
  logic             w_rel_done;
  logic             w_force;
  logic [WIDTH-1:0] w_slice [N_REQ];

  genvar g;
  for (g = 0; g < N_REQ; g++) begin : g_slice
    assign w_slice[g] = i_DATA[g*WIDTH +: WIDTH];
  end

  assign w_pick     = f_pick(i_REQ, r_ptr);
  assign w_rel_done = i_DONE[r_owner] | ~i_REQ[r_owner];

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int            CW          = $clog2(MAX_HOLD+1);
  localparam logic [CW-1:0] L_HOLD_LAST = CW'(MAX_HOLD-1);

  logic [CW-1:0] r_cnt;
  logic          r_timeout;

  assign w_force = (r_state == S_GRANT) & ~w_rel_done & (r_cnt == L_HOLD_LAST);

  // Hold counter: zero outside GRANT so it is clear on every entry to GRANT.
  always_ff @(posedge i_SYS_CLOCK) begin
    if (!i_CLEAR_n) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else if (i_HALT) begin
      r_cnt     <= r_cnt;
      r_timeout <= r_timeout;
    end else if (r_state != S_GRANT) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_cnt     <= r_cnt + CW'(1);
      r_timeout <= w_force;
    end
  end

  assign o_TIMEOUT = r_timeout;
`else
  assign w_force   = 1'b0;
  assign o_TIMEOUT = 1'b0;
`endif

  // Next-state and next-grant logic; halt freezes everything.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_gnt_nxt   = r_gnt;
    if (i_HALT) begin
      w_state_nxt = r_state;
    end else begin
      case (r_state)
        S_IDLE, S_RELEASE: begin
          if (|i_REQ) begin
            w_state_nxt = S_GRANT;
            w_owner_nxt = w_pick;
            w_gnt_nxt   = f_onehot(w_pick);
          end else begin
            w_state_nxt = S_IDLE;
            w_gnt_nxt   = '0;
          end
        end
        S_GRANT: begin
          if (w_rel_done || w_force) begin
            w_state_nxt = S_RELEASE;
            w_gnt_nxt   = '0;
            w_ptr_nxt   = f_next(r_owner);
          end else begin
            w_state_nxt = S_GRANT;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = '0;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge i_SYS_CLOCK) begin
    if (!i_CLEAR_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_gnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
      r_gnt   <= w_gnt_nxt;
    end
  end

  // Bus reads zero whenever no one holds a grant.
  always_comb begin
    if (r_state == S_GRANT) begin
      o_BUS = w_slice[r_owner];
    end else begin
      o_BUS = '0;
    end
  end

  assign o_GNT       = r_gnt;
  assign o_BUS_VALID = (r_state == S_GRANT);
  assign o_OWNER     = r_owner;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed-vector bench for bus_arbiter (N_REQ=4, WIDTH=32, MAX_HOLD=3) with a per-cycle scoreboard.
module tb_bus_arbiter;

  typedef struct packed {
    logic [3:0]  gnt;
    logic [31:0] bus;
    logic        valid;
    logic [1:0]  owner;
    logic        to;
  } exp_t;

  logic          clk = 1'b0;
  logic          clr_n, halt;
  logic [3:0]    req, done;
  logic [127:0]  data;
  logic [3:0]    gnt;
  logic [31:0]   bus;
  logic          valid;
  logic [1:0]    owner;
  logic          tmo;

  logic [31:0]   d [4];
  exp_t          q [$];
  exp_t          m;
  int            n_pass  = 0;
  int            n_total = 0;
  int            n_cyc   = 0;

  assign data = {d[3], d[2], d[1], d[0]};

  always #5 clk = ~clk;

  bus_arbiter #(.N_REQ(4), .WIDTH(32), .MAX_HOLD(3)) dut (
    .i_SYS_CLOCK (clk),
    .i_CLEAR_n   (clr_n),
    .i_HALT      (halt),
    .i_REQ       (req),
    .i_DONE      (done),
    .i_DATA      (data),
    .o_GNT       (gnt),
    .o_BUS       (bus),
    .o_BUS_VALID (valid),
    .o_OWNER     (owner),
    .o_TIMEOUT   (tmo)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      $display("FAIL %s cycle %0d: got %h want %h", nm, n_cyc, got, want);
    end else begin
      n_pass++;
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
  task automatic cyc(input logic c, input logic h, input logic [3:0] r, input logic [3:0] dn,
                     input logic [3:0] eg, input logic [1:0] eo, input logic et);
    exp_t e;
    clr_n   = c;
    halt    = h;
    req     = r;
    done    = dn;
    e.gnt   = eg;
    e.valid = (eg != 4'b0000);
    e.bus   = e.valid ? d[eo] : 32'h0000_0000;
    e.owner = eo;
    e.to    = et;
    q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        m = q.pop_front();
        n_cyc++;
        chk("gnt",     32'(gnt),   32'(m.gnt));
        chk("bus",     bus,        m.bus);
        chk("valid",   32'(valid), 32'(m.valid));
        chk("owner",   32'(owner), 32'(m.owner));
        chk("timeout", 32'(tmo),   32'(m.to));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    d[0] = 32'h1111_0000;
    d[1] = 32'h2222_0001;
    d[2] = 32'hDEAD_BEEF;
    d[3] = 32'h4444_0003;

    // reset held with all requesting
    cyc(1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0);
    cyc(1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0);
    cyc(1'b1, 1'b0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0);
    // round robin with wrap; owner 2 drives DEADBEEF
    cyc(1'b1, 1'b0, 4'b1111, 4'b0001, 4'b0000, 2'd0, 1'b0);
    cyc(1'b1, 1'b0, 4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b0);
    cyc(1'b1, 1'b0, 4'b1111, 4'b0010, 4'b0000, 2'd1, 1'b0);
    cyc(1'b1, 1'b0, 4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b0);
    cyc(1'b1, 1'b0, 4'b1111, 4'b0100, 4'b0000, 2'd2, 1'b0);
    cyc(1'b1, 1'b0, 4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b0);
    cyc(1'b1, 1'b0, 4'b1111, 4'b1000, 4'b0000, 2'd3, 1'b0);
    cyc(1'b1, 1'b0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0);
    // done from non-owners is ignored
    cyc(1'b1, 1'b0, 4'b1111, 4'b1110, 4'b0001, 2'd0, 1'b0);
    // done and req drop together: single release
    cyc(1'b1, 1'b0, 4'b1110, 4'b0001, 4'b0000, 2'd0, 1'b0);
    cyc(1'b1, 1'b0, 4'b1110, 4'b0000, 4'b0010, 2'd1, 1'b0);
    // halt swallows the done strobe
    cyc(1'b1, 1'b1, 4'b1111, 4'b0010, 4'b0010, 2'd1, 1'b0);
    cyc(1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b0);
    cyc(1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b0);
    cyc(1'b1, 1'b0, 4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b0);
    cyc(1'b1, 1'b0, 4'b1111, 4'b0010, 4'b0000, 2'd1, 1'b0);
    cyc(1'b1, 1'b0, 4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b0);
    // owner drops req
    cyc(1'b1, 1'b0, 4'b1011, 4'b0000, 4'b0000, 2'd2, 1'b0);
    cyc(1'b1, 1'b0, 4'b1011, 4'b0000, 4'b1000, 2'd3, 1'b0);
    // reset mid-grant returns pointer to 0
    cyc(1'b0, 1'b0, 4'b1001, 4'b0000, 4'b0000, 2'd0, 1'b0);
    cyc(1'b1, 1'b0, 4'b1001, 4'b0000, 4'b0001, 2'd0, 1'b0);
    // release to idle, owner held, done in idle ignored
    cyc(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
    cyc(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
    cyc(1'b1, 1'b0, 4'b0000, 4'b0100, 4'b0000, 2'd0, 1'b0);
    cyc(1'b1, 1'b0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b0);
    // hold limit
    cyc(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0);
    cyc(1'b1, 1'b0, 4'b0110, 4'b0000, 4'b0010, 2'd1, 1'b0);
`ifdef BUS_ARB_TIMEOUT_EN
    cyc(1'b1, 1'b0, 4'b0110, 4'b0000, 4'b0010, 2'd1, 1'b0);
    cyc(1'b1, 1'b0, 4'b0110, 4'b0000, 4'b0010, 2'd1, 1'b0);
    cyc(1'b1, 1'b0, 4'b0110, 4'b0000, 4'b0000, 2'd1, 1'b1);
    cyc(1'b1, 1'b0, 4'b0110, 4'b0000, 4'b0100, 2'd2, 1'b0);
`else
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 4'b0110, 4'b0000, 4'b0010, 2'd1, 1'b0);
    end
    cyc(1'b1, 1'b0, 4'b0110, 4'b0010, 4'b0000, 2'd1, 1'b0);
    cyc(1'b1, 1'b0, 4'b0110, 4'b0000, 4'b0100, 2'd2, 1'b0);
`endif
    // reset dominates halt
    cyc(1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0);
    cyc(1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0);
    cyc(1'b1, 1'b0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0);

    @(posedge clk);
    #2;
    chk("drain", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
